ula_serial: RTL

Bit-serial N-bit ALU sequencer built around the team's 1-bit ALU slice. It latches two N-bit operands and an ALUop, then processes one bit per clock from LSB to MSB, holding the carry in a register between steps. It resolves SLT once the last bit is done and reports the result, zero, carry-out and overflow with a one-cycle `done` pulse. It sits beside the combinational ripple ALU as the low-area alternative: N cycles per operation, one slice of logic.

---
 rtl/ula_pkg.sv | 21 ++
 rtl/ula_bit_slice.sv | 29 ++
 rtl/ula_serial.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the bit-serial ALU: ALUop encodings and sequencer states.
package ula_pkg;

  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN
  } ula_state_e;

  // 011 has no binvert bit but still means SLT, so fold it onto 111.
  function automatic logic [2:0] ula_norm_op(input logic [2:0] op);
    return (op == 3'b011) ? ULA_SLT : op;
  endfunction

endpackage

// File: rtl/ula_bit_slice.sv
// Combinational 1-bit ALU slice: AND / OR / SUM / LESS with optional b inversion.
module ula_bit_slice
  import ula_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       binvert,
  input  logic       cin,
  input  logic       less,
  input  logic [1:0] op,
  output logic       result,
  output logic       cout
);

  logic b_eff;

  always_comb begin
    b_eff = b ^ binvert;
    cout  = (a & b_eff) | (a & cin) | (b_eff & cin);
    // AND/OR deliberately use raw b, so binvert only affects SUM/carry.
    unique case (op)
      2'b00:   result = a & b;
      2'b01:   result = a | b;
      2'b10:   result = a ^ b_eff ^ cin;
      default: result = less;
    endcase
  end

endmodule

// File: rtl/ula_serial.sv
// Bit-serial N-bit ALU: one slice evaluated per clock, LSB first, carry held in a flop.
module ula_serial
  import ula_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   ALUop,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         cout,
  output logic         overf
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  ula_state_e state_q, state_d;

  logic [N-1:0]  a_q, a_d, b_q, b_d, sr_q, sr_d, result_q, result_d;
  logic [2:0]    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          msb_c_q, msb_c_d, msb_ov_q, msb_ov_d, set_q, set_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          zero_q, zero_d, cout_q, cout_d, overf_q, overf_d;

  logic          slice_res, slice_cout, sum_bit;
  logic [N-1:0]  fin_res;

  ula_bit_slice u_slice (
    .a       (a_q[0]),
    .b       (b_q[0]),
    .binvert (op_q[2]),
    .cin     (carry_q),
    .less    (1'b0),
    .op      (op_q[1:0]),
    .result  (slice_res),
    .cout    (slice_cout)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == LAST) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    msb_c_d  = msb_c_q;
    msb_ov_d = msb_ov_q;
    set_d    = set_q;
    result_d = result_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    overf_d  = overf_q;
    done_d   = 1'b0;
    busy_d   = (state_d != ST_IDLE);
    sum_bit  = a_q[0] ^ b_q[0] ^ op_q[2] ^ carry_q;
    fin_res  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = ula_norm_op(ALUop);
          cnt_d   = '0;
          carry_d = (op_d == ULA_SUB) || (op_d == ULA_SLT);
        end
      end
      ST_RUN: begin
        // Operands shift right so the slice always sees bit 0.
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sr_d    = {slice_res, sr_q[N-1:1]};
        carry_d = slice_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          msb_c_d  = slice_cout;
          msb_ov_d = carry_q ^ slice_cout;
          set_d    = sum_bit ^ (carry_q ^ slice_cout);
        end
      end
      ST_FIN: begin
        if (op_q[1:0] == 2'b11) fin_res[0] = set_q;
        else                    fin_res    = sr_q;
        result_d = fin_res;
        zero_d   = (fin_res == '0);
        cout_d   = op_q[1] & msb_c_q;
        overf_d  = (op_q[1:0] == 2'b10) & msb_ov_q;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      sr_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      msb_c_q  <= 1'b0;
      msb_ov_q <= 1'b0;
      set_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      cout_q   <= 1'b0;
      overf_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      msb_c_q  <= msb_c_d;
      msb_ov_q <= msb_ov_d;
      set_q    <= set_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      overf_q  <= overf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    busy   = busy_q;
    done   = done_q;
    result = result_q;
    zero   = zero_q;
    cout   = cout_q;
    overf  = overf_q;
  end

endmodule
